// File: rtl/localizer_pkg.sv
// Shared types and constants for the localizer frame sequencer.
//   seq_state_t : sequencer FSM states
//   FFT_BEAT_W  : width of one FFT beat (4 mics x 16b re/im, imag in the upper half)
//   BIN_W       : width of a localizer direction bin
//   CNT_W       : width of the frame statistics counters
//   safe_clog2  : $clog2 that never returns 0, so derived vectors keep at least one bit
package localizer_pkg;

    localparam int unsigned FFT_BEAT_W = 128;
    localparam int unsigned BIN_W      = 4;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        STREAM      = 2'd1,
        WAIT_RESULT = 2'd2
    } seq_state_t;

    function automatic int unsigned safe_clog2(input int unsigned value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the frame statistics.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : increment request, ignored once the count is all ones
//   count : current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/localizer_frame_sequencer.sv
// Admits whole FFT frames into the localizer datapath, decimates the frame rate and waits for the
// localizer's bin result with a timeout. One frame is in flight at a time.
//   clk_in / rst_n_in                : clock, asynchronous active-low reset
//   fft_data_in/valid_in/last_in     : FFT output stream (cannot be stalled)
//   loc_ready_in                     : localizer ready to take a frame
//   loc_data/valid/last_out          : registered forward of admitted beats (1-cycle latency)
//   beat_idx_out                     : index of the forwarded beat within its frame
//   bin_in / bin_valid_in            : localizer result
//   bin_out / bin_valid_out          : last accepted bin, pulse on update
//   busy_out                         : sequencer not idle
//   timeout_out                      : pulse when a result did not arrive in time
//   overrun_out                      : sticky, localizer dropped ready mid-frame
//   frames_done_out / dropped_out    : saturating frame statistics
module localizer_frame_sequencer
    import localizer_pkg::*;
#(
    parameter int unsigned FFT_SIZE       = 1024,
    parameter int unsigned DECIMATE       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic [FFT_BEAT_W-1:0]           fft_data_in,
    input  logic                            fft_valid_in,
    input  logic                            fft_last_in,
    input  logic                            loc_ready_in,
    output logic [FFT_BEAT_W-1:0]           loc_data_out,
    output logic                            loc_valid_out,
    output logic                            loc_last_out,
    output logic [safe_clog2(FFT_SIZE)-1:0] beat_idx_out,
    input  logic [BIN_W-1:0]                bin_in,
    input  logic                            bin_valid_in,
    output logic [BIN_W-1:0]                bin_out,
    output logic                            bin_valid_out,
    output logic                            busy_out,
    output logic                            timeout_out,
    output logic                            overrun_out,
    output logic [CNT_W-1:0]                frames_done_out,
    output logic [CNT_W-1:0]                frames_dropped_out
);

    localparam int unsigned IDX_W = safe_clog2(FFT_SIZE);
    localparam int unsigned DEC_W = safe_clog2(DECIMATE);
    localparam int unsigned TMR_W = safe_clog2(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_SIZE - 1);
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIMATE - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    seq_state_t state_q, state_d;

    // Only a tlast can raise this, so it also serves as the "synced" flag after reset.
    logic                  prev_last_q;
    logic [DEC_W-1:0]      dec_q;
    logic [IDX_W-1:0]      beat_cnt_q;
    logic [TMR_W-1:0]      timer_q;

    logic [FFT_BEAT_W-1:0] loc_data_q;
    logic                  loc_valid_q;
    logic                  loc_last_q;
    logic [IDX_W-1:0]      beat_idx_q;
    logic [BIN_W-1:0]      bin_q;
    logic                  bin_valid_q;
    logic                  timeout_q;
    logic                  overrun_q;

    logic                  frame_start;
    logic                  eligible;
    logic                  fwd;
    logic                  fwd_first;
    logic                  drop_inc;
    logic                  done_inc;
    logic                  bin_accept;
    logic                  timeout_d;
    logic [IDX_W-1:0]      idx_cur;
    logic [IDX_W-1:0]      idx_next;

    assign frame_start = fft_valid_in & prev_last_q;
    assign eligible    = (dec_q == '0);

    // Next-state and per-cycle control
    always_comb begin
        state_d    = state_q;
        fwd        = 1'b0;
        fwd_first  = 1'b0;
        drop_inc   = 1'b0;
        done_inc   = 1'b0;
        bin_accept = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_start && eligible) begin
                    if (loc_ready_in) begin
                        fwd       = 1'b1;
                        fwd_first = 1'b1;
                        // A 1-beat frame is complete on admission.
                        state_d   = fft_last_in ? WAIT_RESULT : STREAM;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (fft_valid_in) begin
                    fwd = 1'b1;
                    if (fft_last_in) begin
                        state_d = WAIT_RESULT;
                    end
                end
            end
            WAIT_RESULT: begin
                if (frame_start && eligible) begin
                    drop_inc = 1'b1;
                end
                // A result on the expiry cycle wins over the timeout.
                if (bin_valid_in) begin
                    bin_accept = 1'b1;
                    done_inc   = 1'b1;
                    state_d    = IDLE;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_cur  = fwd_first ? '0 : beat_cnt_q;
        idx_next = (idx_cur == IDX_LAST) ? '0 : idx_cur + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            prev_last_q <= 1'b0;
            dec_q       <= '0;
            beat_cnt_q  <= '0;
            timer_q     <= '0;
        end else begin
            state_q <= state_d;
            if (fft_valid_in) begin
                prev_last_q <= fft_last_in;
            end
            if (frame_start) begin
                dec_q <= (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
            end
            if (fwd) begin
                beat_cnt_q <= idx_next;
            end
            // Held at zero outside WAIT_RESULT so it starts from 0 on entry.
            if (state_q == WAIT_RESULT) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            loc_data_q  <= '0;
            loc_valid_q <= 1'b0;
            loc_last_q  <= 1'b0;
            beat_idx_q  <= '0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            loc_valid_q <= fwd;
            loc_last_q  <= fwd & fft_last_in;
            if (fwd) begin
                loc_data_q <= fft_data_in;
                beat_idx_q <= idx_cur;
            end
            if (bin_accept) begin
                bin_q <= bin_in;
            end
            bin_valid_q <= bin_accept;
            timeout_q   <= timeout_d;
            if ((state_q == STREAM) && fft_valid_in && !loc_ready_in) begin
                overrun_q <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_done_cnt (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .inc   (done_inc),
        .count (frames_done_out)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_dropped_cnt (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .inc   (drop_inc),
        .count (frames_dropped_out)
    );

    assign loc_data_out  = loc_data_q;
    assign loc_valid_out = loc_valid_q;
    assign loc_last_out  = loc_last_q;
    assign beat_idx_out  = beat_idx_q;
    assign bin_out       = bin_q;
    assign bin_valid_out = bin_valid_q;
    assign busy_out      = (state_q != IDLE);
    assign timeout_out   = timeout_q;
    assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_localizer_frame_sequencer.sv
// Bench for localizer_frame_sequencer: scoreboard of forwarded beats plus statistic checks.
module tb_localizer_frame_sequencer;

    localparam int unsigned FFT = 1024;
    localparam int unsigned DEC = 4;
    localparam int unsigned TMO = 64;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic [9:0]   idx;
    } beat_t;

    logic         clk_in;
    logic         rst_n_in;
    logic [127:0] fft_data_in;
    logic         fft_valid_in;
    logic         fft_last_in;
    logic         loc_ready_in;
    logic [127:0] loc_data_out;
    logic         loc_valid_out;
    logic         loc_last_out;
    logic [9:0]   beat_idx_out;
    logic [3:0]   bin_in;
    logic         bin_valid_in;
    logic [3:0]   bin_out;
    logic         bin_valid_out;
    logic         busy_out;
    logic         timeout_out;
    logic         overrun_out;
    logic [15:0]  frames_done_out;
    logic [15:0]  frames_dropped_out;

    localizer_frame_sequencer #(
        .FFT_SIZE       (FFT),
        .DECIMATE       (DEC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .fft_data_in        (fft_data_in),
        .fft_valid_in       (fft_valid_in),
        .fft_last_in        (fft_last_in),
        .loc_ready_in       (loc_ready_in),
        .loc_data_out       (loc_data_out),
        .loc_valid_out      (loc_valid_out),
        .loc_last_out       (loc_last_out),
        .beat_idx_out       (beat_idx_out),
        .bin_in             (bin_in),
        .bin_valid_in       (bin_valid_in),
        .bin_out            (bin_out),
        .bin_valid_out      (bin_valid_out),
        .busy_out           (busy_out),
        .timeout_out        (timeout_out),
        .overrun_out        (overrun_out),
        .frames_done_out    (frames_done_out),
        .frames_dropped_out (frames_dropped_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    // Reference model state
    bit    synced = 0;
    int    dec = 0;
    int    exp_done = 0;
    int    exp_drop = 0;

    // Observation state
    int    cyc = 0;
    bit    busy_s = 0;
    int    last_cyc = 0;
    int    to_cyc = 0;
    bit    to_busy = 0;
    int    timeout_cnt = 0;
    int    binv_cnt = 0;
    int    binv_cyc = 0;

    // Result responder
    int       resp_delay = -1;
    int       resp_cnt = -1;
    logic [3:0] resp_bin = 4'h5;
    bit       spur_req = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        beat_t e;
        busy_s = busy_out;
        if (loc_valid_out) begin
            if (exp_q.size() == 0) begin
                check("beat_unexpected", {loc_valid_out, beat_idx_out}, 11'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat", {loc_data_out, loc_last_out, beat_idx_out}, e);
            end
            if (loc_last_out) begin
                last_cyc = cyc;
                if (resp_delay >= 1) resp_cnt = resp_delay;
            end
        end
        if (timeout_out) begin
            timeout_cnt++;
            to_cyc  = cyc;
            to_busy = busy_out;
        end
        if (bin_valid_out) begin
            binv_cnt++;
            binv_cyc = cyc;
        end
    endtask

    // Sample at the falling edge, let the rising edge capture inputs, then drive the responder.
    task automatic step();
        @(negedge clk_in);
        sample();
        @(posedge clk_in);
        #1;
        cyc++;
        bin_valid_in = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                bin_valid_in = 1'b1;
                bin_in       = resp_bin;
                resp_cnt     = -1;
            end
        end
        if (spur_req) begin
            bin_valid_in = 1'b1;
            bin_in       = 4'h3;
            spur_req     = 0;
        end
    endtask

    task automatic idle(input int n);
        fft_valid_in = 1'b0;
        fft_last_in  = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_idle(input int max);
        int k;
        fft_valid_in = 1'b0;
        for (k = 0; k < max; k++) begin
            step();
            if (!busy_s && resp_cnt < 0) break;
        end
        check("wait_idle", busy_s, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {loc_valid_out, loc_last_out, busy_out, bin_valid_out,
                                timeout_out, overrun_out}, 0);
        check({tag, "_data"}, loc_data_out, 0);
        check({tag, "_idx_bin"}, {beat_idx_out, bin_out}, 0);
        check({tag, "_counters"}, {frames_done_out, frames_dropped_out}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        sample();
        #1 rst_n_in = 1'b0;
        #1 check_all_zero("mid_reset");
        check("mid_reset_q", exp_q.size(), 0);
        synced = 0; dec = 0; exp_done = 0; exp_drop = 0;
        binv_cnt = 0; timeout_cnt = 0; resp_cnt = -1;
        @(posedge clk_in);
        #1 cyc++;
        step();
        rst_n_in = 1'b1;
    endtask

    // Drive an n-beat frame (last on the final beat); rst_at >= 0 aborts it with a reset.
    task automatic send_frame(input int n, input bit rdy0, input int rdy_drop_at, input bit busy,
                              input int rst_at);
        bit    admit;
        beat_t b;
        admit = 0;
        if (synced) begin
            if (dec == 0) begin
                if (rdy0 && !busy) admit = 1;
                else exp_drop++;
            end
            dec = (dec + 1) % DEC;
        end
        for (int i = 0; i < n; i++) begin
            fft_valid_in = 1'b1;
            fft_last_in  = (i == n - 1);
            fft_data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
            loc_ready_in = (i == 0) ? rdy0 : !(rdy_drop_at >= 0 && i >= rdy_drop_at);
            if (i == rst_at) begin
                do_reset();
                fft_valid_in = 1'b0;
                loc_ready_in = 1'b1;
                return;
            end
            if (admit) begin
                b.data = fft_data_in;
                b.last = fft_last_in;
                b.idx  = 10'(i);
                exp_q.push_back(b);
            end
            step();
        end
        synced       = 1;
        fft_valid_in = 1'b0;
        fft_last_in  = 1'b0;
        loc_ready_in = 1'b1;
    endtask

    task automatic fillers();
        for (int f = 0; f < 3; f++) send_frame(1, 1, -1, 0, -1);
    endtask

    initial begin
        rst_n_in     = 1'b0;
        fft_data_in  = '0;
        fft_valid_in = 1'b0;
        fft_last_in  = 1'b0;
        loc_ready_in = 1'b1;
        bin_in       = '0;
        bin_valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 check_all_zero("reset");
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;

        // Partial frame after reset must not be forwarded; next full frame is.
        send_frame(300, 1, -1, 0, -1);
        resp_delay = 50;
        resp_bin   = 4'h5;
        send_frame(FFT, 1, -1, 0, -1);
        exp_done++;
        wait_idle(200);
        check("t1_q_empty", exp_q.size(), 0);
        check("t1_done", frames_done_out, exp_done);
        check("t1_bin", bin_out, 4'h5);

        // Eight back-to-back frames with decimation.
        fillers();
        for (int f = 0; f < 8; f++) send_frame(FFT, 1, -1, 0, -1);
        exp_done += 2;
        wait_idle(200);
        check("t2_done", frames_done_out, exp_done);
        check("t2_dropped", frames_dropped_out, exp_drop);
        check("t2_q_empty", exp_q.size(), 0);

        // Not ready at frame start, then ready lost mid-frame.
        send_frame(FFT, 0, -1, 0, -1);
        check("t3_dropped", frames_dropped_out, 16'd1);
        check("t3_no_overrun", overrun_out, 0);
        fillers();
        send_frame(FFT, 1, 300, 0, -1);
        exp_done++;
        wait_idle(200);
        check("t3_overrun", overrun_out, 1);
        check("t3_done", frames_done_out, exp_done);
        check("t3_q_empty", exp_q.size(), 0);

        // Timeout, with an eligible start landing on the exit cycle.
        fillers();
        resp_delay = -1;
        send_frame(FFT, 1, -1, 0, -1);
        for (int f = 0; f < 3; f++) send_frame(1, 1, -1, 1, -1);
        idle(60);
        send_frame(1, 1, -1, 1, -1);
        wait_idle(200);
        check("t4_timeout_cnt", timeout_cnt, 1);
        check("t4_timeout_lat", to_cyc - last_cyc, TMO);
        check("t4_busy_at_timeout", to_busy, 0);
        check("t4_dropped", frames_dropped_out, exp_drop);
        check("t4_done", frames_done_out, exp_done);

        // Result on the last timer cycle wins.
        fillers();
        resp_delay = TMO - 1;
        resp_bin   = 4'hA;
        send_frame(FFT, 1, -1, 0, -1);
        exp_done++;
        wait_idle(200);
        idle(2);
        check("t4b_timeout_cnt", timeout_cnt, 1);
        check("t4b_bin_lat", binv_cyc - last_cyc, TMO);
        check("t5_bin", bin_out, 4'hA);
        check("t4b_done", frames_done_out, exp_done);
        check("t4b_binv_cnt", binv_cnt, exp_done);

        // Spurious result while idle is ignored.
        spur_req = 1;
        idle(4);
        check("t5_spur_bin", bin_out, 4'hA);
        check("t5_spur_binv", binv_cnt, exp_done);
        check("t5_spur_done", frames_done_out, exp_done);
        check("t5_overrun_sticky", overrun_out, 1);

        // Reset mid-frame; rest of the frame is discarded, the next one admitted.
        fillers();
        resp_delay = 50;
        resp_bin   = 4'h7;
        send_frame(FFT, 1, -1, 0, 500);
        send_frame(FFT - 500, 1, -1, 0, -1);
        check("t6_q_empty_unsynced", exp_q.size(), 0);
        send_frame(FFT, 1, -1, 0, -1);
        exp_done++;
        wait_idle(200);
        check("t6_done", frames_done_out, exp_done);
        check("t6_dropped", frames_dropped_out, exp_drop);
        check("t6_bin", bin_out, 4'h7);
        check("t6_overrun", overrun_out, 0);
        check("t6_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
